// File: rtl/ram_uart_bridge.sv
// UART-to-SRAM command bridge: parses W/R frames from received bytes, performs
// one RAM access with a done-handshake and timeout, and returns a status or read data.
module ram_uart_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  CMD_W   = 8'h57,
  parameter logic [7:0]  CMD_R   = 8'h52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        ram_en,
  output logic        ram_re,
  output logic        ram_we,
  output logic [16:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_done,
  input  logic [15:0] ram_rdata,
  output logic        rx_overrun
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  RSP_OK  = 8'h4B;
  localparam logic [7:0]  RSP_TMO = 8'hEE;

  typedef enum logic [3:0] {
    IDLE, GET_A2, GET_A1, GET_A0, GET_D1, GET_D0,
    RAM_REQ, RAM_WAIT, RAM_REL, TX_B0, TX_B1, TX_WAIT
  } state_e;

  state_e             state_q;
  logic               op_wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         b0_q;
  logic [7:0]         b1_q;
  logic               two_q;
  logic [1:0]         hold_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               ram_en_q;
  logic               ram_re_q;
  logic               ram_we_q;
  logic [16:0]        ram_addr_q;
  logic [15:0]        ram_wdata_q;
  logic               rx_overrun_q;
  logic               rx_accept_c;

  // Bytes are only consumed while parsing a frame; anything else is an overrun.
  assign rx_accept_c = (state_q == IDLE)   || (state_q == GET_A2) ||
                       (state_q == GET_A1) || (state_q == GET_A0) ||
                       (state_q == GET_D1) || (state_q == GET_D0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_wr_q      <= 1'b0;
      cnt_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      two_q        <= 1'b0;
      hold_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      ram_en_q     <= 1'b1;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      rx_overrun_q <= rx_ready && !rx_accept_c;

      case (state_q)
        IDLE: begin
          if (rx_ready && (rx_data == CMD_W || rx_data == CMD_R)) begin
            op_wr_q <= (rx_data == CMD_W);
            state_q <= GET_A2;
          end
        end
        GET_A2: begin
          if (rx_ready) begin
            ram_addr_q[16] <= rx_data[0];
            state_q        <= GET_A1;
          end
        end
        GET_A1: begin
          if (rx_ready) begin
            ram_addr_q[15:8] <= rx_data;
            state_q          <= GET_A0;
          end
        end
        GET_A0: begin
          if (rx_ready) begin
            ram_addr_q[7:0] <= rx_data;
            if (op_wr_q) begin
              state_q <= GET_D1;
            end else begin
              ram_en_q <= 1'b0;
              ram_re_q <= 1'b1;
              ram_we_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= RAM_REQ;
            end
          end
        end
        GET_D1: begin
          if (rx_ready) begin
            ram_wdata_q[15:8] <= rx_data;
            state_q           <= GET_D0;
          end
        end
        GET_D0: begin
          if (rx_ready) begin
            ram_wdata_q[7:0] <= rx_data;
            ram_en_q         <= 1'b0;
            ram_re_q         <= 1'b0;
            ram_we_q         <= 1'b1;
            cnt_q            <= '0;
            state_q          <= RAM_REQ;
          end
        end
        RAM_REQ: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= RAM_WAIT;
        end
        // Completion wins over timeout when both land in the same cycle.
        RAM_WAIT: begin
          if (ram_done) begin
            ram_en_q <= 1'b1;
            ram_re_q <= 1'b0;
            ram_we_q <= 1'b0;
            b0_q     <= op_wr_q ? RSP_OK : ram_rdata[15:8];
            b1_q     <= ram_rdata[7:0];
            two_q    <= !op_wr_q;
            state_q  <= RAM_REL;
          end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            ram_en_q <= 1'b1;
            ram_re_q <= 1'b0;
            ram_we_q <= 1'b0;
            b0_q     <= RSP_TMO;
            two_q    <= 1'b0;
            state_q  <= RAM_REL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RAM_REL: begin
          state_q <= TX_B0;
        end
        TX_B0: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= b0_q;
            hold_q     <= 2'd2;
            state_q    <= TX_WAIT;
          end
        end
        TX_B1: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= b1_q;
            two_q      <= 1'b0;
            hold_q     <= 2'd2;
            state_q    <= TX_WAIT;
          end
        end
        // The transmitter needs a cycle to raise busy, so skip it right after a pulse.
        TX_WAIT: begin
          if (hold_q != 2'd0) begin
            hold_q <= hold_q - 2'd1;
          end else if (!tx_busy) begin
            state_q <= two_q ? TX_B1 : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign ram_en     = ram_en_q;
  assign ram_re     = ram_re_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_ram_uart_bridge.sv
// Directed bench for ram_uart_bridge: RAM and UART-transmitter models plus a
// scoreboard of expected response bytes.
module tb_ram_uart_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        ram_en;
  logic        ram_re;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_done = 1'b0;
  logic [15:0] ram_rdata;
  logic        rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  logic [16:0] exp_addr;
  logic        exp_we;
  logic [15:0] exp_wdata;
  int          done_delay;
  int          en_low_cnt = 0;
  int          last_low   = 0;
  int          acc_cnt    = 0;
  int          busy_cnt   = 0;
  int          tx_cnt     = 0;
  int          ovr_cnt    = 0;
  logic        ovr_prev   = 1'b0;

  ram_uart_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .ram_en     (ram_en),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_done   (ram_done),
    .ram_rdata  (ram_rdata),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter, overrun and RAM models, all sampled on the falling edge.
  always @(negedge clk) begin
    int pending;
    if (tx_start === 1'b1) begin
      tx_cnt++;
      pending = exp_q.size();
      check("tx_start_while_idle", tx_busy, 1'b0);
      check("tx_byte_expected", pending != 0, 1'b1);
      if (pending != 0) check("tx_byte", tx_data, exp_q.pop_front());
      busy_cnt = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);

    if (rx_overrun === 1'b1) begin
      ovr_cnt++;
      check("overrun_width", ovr_prev, 1'b0);
    end
    ovr_prev = (rx_overrun === 1'b1);

    ram_done = 1'b0;
    if (ram_en === 1'b0) begin
      if (en_low_cnt == 0) acc_cnt++;
      check("ram_we", ram_we, exp_we);
      check("ram_re", ram_re, !exp_we);
      check("ram_addr", ram_addr, exp_addr);
      if (exp_we) check("ram_wdata", ram_wdata, exp_wdata);
      if (en_low_cnt == done_delay) ram_done = 1'b1;
      en_low_cnt++;
    end else if (en_low_cnt != 0) begin
      last_low   = en_low_cnt;
      en_low_cnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] a2,
                          input logic [7:0] a1, input logic [7:0] a0);
    send_byte(c);
    send_byte(a2);
    send_byte(a1);
    send_byte(a0);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || tx_busy || ram_en !== 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_in_time"}, t < 2000, 1'b1);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ram_low(input string tag);
    int t = 0;
    while (ram_en !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ram_req_seen"}, t < 100, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0;
    int o0;
    int t0;
    rst        = 1'b1;
    rx_ready   = 1'b0;
    rx_data    = 8'h00;
    ram_rdata  = 16'h0000;
    done_delay = -1;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    repeat (3) @(negedge clk);

    check("rst_ram_en", ram_en, 1'b1);
    check("rst_ram_re", ram_re, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 17'h0);
    check("rst_ram_wdata", ram_wdata, 16'h0);
    check("rst_tx_data", tx_data, 8'h0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_rx_overrun", rx_overrun, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xABCD to 0x01234, done after 3 cycles.
    exp_we = 1'b1; exp_addr = 17'h01234; exp_wdata = 16'hABCD; done_delay = 3;
    exp_q.push_back(8'h4B);
    a0 = acc_cnt;
    send_hdr(8'h57, 8'h00, 8'h12, 8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    wait_idle("write");
    check("write_en_low_cycles", last_low, 4);
    check("write_access_count", acc_cnt - a0, 1);

    // Read bank 2, data returned high byte first.
    exp_we = 1'b0; exp_addr = 17'h1FFFE; ram_rdata = 16'hBEEF; done_delay = 2;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    send_hdr(8'h52, 8'h01, 8'hFF, 8'hFE);
    wait_idle("read");
    check("read_en_low_cycles", last_low, 3);

    // Read that never completes.
    exp_addr = 17'h00005; done_delay = -1;
    exp_q.push_back(8'hEE);
    send_hdr(8'h52, 8'h00, 8'h00, 8'h05);
    wait_idle("timeout");
    check("timeout_en_low_cycles", last_low, 255);

    // Unknown command byte is discarded.
    a0 = acc_cnt;
    send_byte(8'h41);
    repeat (5) @(negedge clk);
    check("junk_no_access", acc_cnt - a0, 0);
    exp_addr = 17'h00001; ram_rdata = 16'h1234; done_delay = 1;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_hdr(8'h52, 8'h00, 8'h00, 8'h01);
    wait_idle("after_junk");
    check("after_junk_access", acc_cnt - a0, 1);
    check("after_junk_en_low", last_low, 2);
    check("no_overrun_yet", ovr_cnt, 0);

    // Byte arriving mid-access; upper A2 bits ignored.
    exp_addr = 17'h0ABCD; ram_rdata = 16'h5A0F; done_delay = 6;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0F);
    o0 = ovr_cnt;
    send_hdr(8'h52, 8'hFE, 8'hAB, 8'hCD);
    wait_ram_low("overrun");
    send_byte(8'h99);
    wait_idle("overrun");
    check("overrun_pulses", ovr_cnt - o0, 1);
    check("overrun_en_low", last_low, 7);

    // Reset while waiting on the RAM.
    exp_addr = 17'h00010; done_delay = -1;
    t0 = tx_cnt;
    send_hdr(8'h52, 8'h00, 8'h00, 8'h10);
    wait_ram_low("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ram_en", ram_en, 1'b1);
    check("reset_ram_re", ram_re, 1'b0);
    check("reset_tx_start", tx_start, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("reset_no_tx", tx_cnt - t0, 0);

    exp_we = 1'b1; exp_addr = 17'h10002; exp_wdata = 16'h1122; done_delay = 3;
    exp_q.push_back(8'h4B);
    send_hdr(8'h57, 8'h01, 8'h00, 8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_idle("post_reset");
    check("post_reset_en_low", last_low, 4);
    check("post_reset_tx_count", tx_cnt - t0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_uart_bridge.md
RAM_UART_BRIDGE -- requirements
Module: ram_uart_bridge

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 255, giving the max cycles to wait for ram_done before aborting.
REQ-002 The block SHALL provide parameter CMD_W, default 8'h57 ('W'), as the write command byte.
REQ-003 The block SHALL provide parameter CMD_R, default 8'h52 ('R'), as the read command byte.
REQ-004 The block SHALL provide port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL provide port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL provide port rx_data, input, 8, the received UART byte, valid when rx_ready=1.
REQ-007 The block SHALL provide port rx_ready, input, 1, a one-cycle pulse per received byte.
REQ-008 The block SHALL provide port tx_data, output, 8, the byte to transmit, valid when tx_start=1.
REQ-009 The block SHALL provide port tx_start, output, 1, a one-cycle transmit request.
REQ-010 The block SHALL provide port tx_busy, input, 1, high while the UART transmitter is sending.
REQ-011 The block SHALL provide port ram_en, output, 1, the active-low RAM request (1 = idle).
REQ-012 The block SHALL provide ports ram_re and ram_we, outputs, 1 each, one-hot read/write select, active-high.
REQ-013 The block SHALL provide port ram_addr, output, 17; bit 16 selects bank (0 = RAM1, 1 = RAM2).
REQ-014 The block SHALL provide port ram_wdata, output, 16, the write data.
REQ-015 The block SHALL provide ports ram_done (input, 1, access complete) and ram_rdata (input, 16, read data, valid when ram_done=1).
REQ-016 The block SHALL provide port rx_overrun, output, 1, a one-cycle pulse when a received byte is dropped.

Function
REQ-017 Frame format SHALL be: CMD, A2, A1, A0, then D1, D0 for writes only; ram_addr = {A2[0], A1, A0}; ram_wdata = {D1, D0}; A2[7:1] is ignored.
REQ-018 The FSM SHALL use states IDLE, GET_A2, GET_A1, GET_A0, GET_D1, GET_D0, RAM_REQ, RAM_WAIT, RAM_REL, TX_B0, TX_B1, TX_WAIT.
REQ-019 IDLE: rx_ready with CMD_W or CMD_R SHALL latch the op and go to GET_A2; any other byte SHALL be silently discarded and the FSM stays in IDLE.
REQ-020 Each GET_* state SHALL advance only on rx_ready; there is no inter-byte timeout.
REQ-021 After GET_A0, reads SHALL go to RAM_REQ; after GET_D0, writes SHALL go to RAM_REQ.
REQ-022 RAM_REQ (1 cycle): ram_en=0, the matching select=1, and addr/wdata driven; the FSM then enters RAM_WAIT.
REQ-023 RAM_WAIT: ram_en, ram_re/ram_we, ram_addr and ram_wdata SHALL stay stable until ram_done=1 is sampled.
REQ-024 On ram_done in RAM_WAIT for a read, ram_rdata SHALL be captured on that same edge.
REQ-025 RAM_REL: ram_en=1 and ram_re=ram_we=0 for exactly one cycle, then the FSM enters TX_B0.
REQ-026 A cycle counter SHALL run from RAM_REQ; if ram_done is not seen within TIMEOUT cycles, the FSM SHALL go to RAM_REL and the response SHALL be the single byte 8'hEE.
REQ-027 The response SHALL be: write OK = single byte 8'h4B; read = rdata[15:8] then rdata[7:0]; timeout = 8'hEE.
REQ-028 TX_B0/TX_B1: tx_start SHALL pulse for one cycle only in a cycle where tx_busy=0; tx_busy SHALL be ignored in the cycle after the pulse; TX_WAIT then waits for tx_busy=0 before the next byte or the return to IDLE.
REQ-029 An rx_ready while the FSM is outside IDLE/GET_* SHALL drop the byte and pulse rx_overrun for one cycle.
REQ-030 ram_done while the FSM is not in RAM_WAIT SHALL be ignored.
REQ-031 Idle outputs SHALL be: ram_en=1, ram_re=ram_we=0, tx_start=0, rx_overrun=0.

Reset
REQ-032 On rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs take their reset values: ram_en=1, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0, tx_data=0, tx_start=0, rx_overrun=0.
REQ-033 Reset mid-frame or mid-access SHALL discard the partial frame and release the RAM request on that same edge, with no response byte sent.

Verification
REQ-034 Bytes 57,00,12,34,AB,CD with ram_done after 3 cycles -> ram_en low for 4 cycles, ram_we=1, addr=0x01234, wdata=0xABCD, then one tx byte 4B.
REQ-035 Bytes 52,01,FF,FE with ram_done/rdata=0xBEEF after 2 cycles -> ram_re=1, addr=0x1FFFE, tx bytes BE then EF, each only while tx_busy=0.
REQ-036 Read with ram_done never asserted -> ram_en=1 after TIMEOUT cycles, tx byte EE, FSM back in IDLE.
REQ-037 Bytes 41, then 52,00,00,01 -> 41 ignored with no RAM activity, then a normal read of addr 0x00001.
REQ-038 A byte received during RAM_WAIT -> rx_overrun one-cycle pulse, byte dropped, and the access completes normally.
REQ-039 rst asserted in RAM_WAIT -> ram_en=1 on the next edge, no tx_start, and the next frame is processed normally.
